// File: rtl/dmem_sram_like_bridge_pkg.sv
// Shared types and constants for the data-side sram-like bus bridge.
// Holds the FSM state encoding and the bus transfer-size codes.
package dmem_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } bridgeState_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Any enabled byte lane marks the access as a store.
    function automatic logic isStore(input logic [3:0] wen);
        return |wen;
    endfunction

endpackage

// File: rtl/dmem_sram_like_bridge.sv
// Converts the core's single-cycle M-stage data access into one sram-like
// req/addr_ok/data_ok transaction, stalling the core until it completes.
module dmem_sram_like_bridge
    import dmem_sram_like_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              except_flush,
    input  logic              cpu_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    bridgeState_e state;
    logic         discard;
    logic         dropNow;

    // A flush arriving together with data_ok still cancels the response.
    assign dropNow = discard | except_flush;

    // HOLD means the current M-stage access has already completed.
    assign d_stall = mem_en & ~except_flush & (state != HOLD);

    // Transaction FSM with the request-latch register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            discard    <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wdata <= '0;
            mem_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (mem_en && !except_flush) begin
                        data_wr    <= isStore(mem_wen);
                        data_size  <= mem_size;
                        data_addr  <= mem_addr;
                        data_wdata <= mem_wdata;
                        data_req   <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (except_flush) begin
                        discard <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (except_flush) begin
                        discard <= 1'b1;
                    end
                    if (data_data_ok) begin
                        if (dropNow) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            if (!data_wr) begin
                                mem_rdata <= data_rdata;
                            end
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Leave only when the instruction moves out of M.
                    if (except_flush || !cpu_stall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sram_like_bridge.sv
// Self-checking bench: transaction-level model of the bridge, directed
// scenarios with literal expectations, then randomized core and slave traffic.
module tb_dmem_sram_like_bridge;
    import dmem_sram_like_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        except_flush;
    logic        cpu_stall;
    logic [31:0] mem_rdata;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    dmem_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .except_flush(except_flush), .cpu_stall(cpu_stall),
        .mem_rdata(mem_rdata), .d_stall(d_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Stimulus values applied at the next falling edge.
    logic        vEn, vFlush, vStall, vAddrOk, vDataOk;
    logic [3:0]  vWen;
    logic [1:0]  vSize;
    logic [31:0] vAddr, vWdata, vRdata;

    // Transaction-level model: a request offered on the bus, an accepted
    // request awaiting its data, and a completed access still sitting in M.
    logic        mReqPend, mReqDrop, mOutValid, mOutDrop, mOutWr, mDone;
    logic        mWr;
    logic [1:0]  mSize;
    logic [31:0] mAddr, mWdata, mRdata;
    logic        lastExpStall;

    int stallCycles, reqCycles, freeCycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mReqPend = 0; mReqDrop = 0; mOutValid = 0; mOutDrop = 0; mOutWr = 0; mDone = 0;
        mWr = 0; mSize = 2'd0; mAddr = 32'd0; mWdata = 32'd0; mRdata = 32'd0;
    endtask

    task automatic setInstr(input logic en, input logic [3:0] wen, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
        vEn = en; vWen = wen; vSize = sz; vAddr = a; vWdata = wd;
    endtask

    task automatic setBus(input logic ao, input logic dok, input logic [31:0] rd);
        vAddrOk = ao; vDataOk = dok; vRdata = rd;
    endtask

    task automatic applyInputs();
        mem_en = vEn; mem_wen = vWen; mem_size = vSize; mem_addr = vAddr;
        mem_wdata = vWdata; except_flush = vFlush; cpu_stall = vStall;
        data_addr_ok = vAddrOk; data_data_ok = vDataOk; data_rdata = vRdata;
    endtask

    // One clock: drive, compare against the model, then advance the model.
    task automatic cycle();
        logic expStall;
        logic drop;
        @(negedge clk);
        applyInputs();
        #1;
        expStall = vEn & ~vFlush & ~mDone;
        chk("d_stall", {31'd0, d_stall}, {31'd0, expStall});
        chk("data_req", {31'd0, data_req}, {31'd0, mReqPend});
        chk("data_wr", {31'd0, data_wr}, {31'd0, mWr});
        chk("data_size", {30'd0, data_size}, {30'd0, mSize});
        chk("data_addr", data_addr, mAddr);
        chk("data_wdata", data_wdata, mWdata);
        chk("mem_rdata", mem_rdata, mRdata);
        if (d_stall) stallCycles++;
        if (data_req) reqCycles++;
        if (mem_en && !d_stall) freeCycles++;
        lastExpStall = expStall;
        if (mReqPend) begin
            if (vFlush) mReqDrop = 1;
            if (vAddrOk) begin
                mReqPend = 0; mOutValid = 1; mOutDrop = mReqDrop; mOutWr = mWr;
            end
        end else if (mOutValid) begin
            drop = mOutDrop | vFlush;
            mOutDrop = drop;
            if (vDataOk) begin
                mOutValid = 0;
                if (!drop) begin
                    mDone = 1;
                    if (!mOutWr) mRdata = vRdata;
                end
            end
        end else if (mDone) begin
            if (vFlush || !vStall) mDone = 0;
        end else if (vEn && !vFlush) begin
            mReqPend = 1; mReqDrop = 0;
            mWr = |vWen; mSize = vSize; mAddr = vAddr; mWdata = vWdata;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        setInstr(0, 4'd0, 2'd0, 32'd0, 32'd0);
        setBus(0, 0, 32'd0);
        vFlush = 0; vStall = 0;
        applyInputs();
        rst = 1'b1;
        #1;
        chk("rst_data_req", {31'd0, data_req}, 32'd0);
        chk("rst_data_wr", {31'd0, data_wr}, 32'd0);
        chk("rst_data_size", {30'd0, data_size}, 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        chk("rst_data_wdata", data_wdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_d_stall", {31'd0, d_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic clrCnt();
        stallCycles = 0; reqCycles = 0; freeCycles = 0;
    endtask

    logic sBusy;
    int   sCnt;
    logic hold;

    initial begin
        rst = 1'b1;
        vFlush = 0; vStall = 0;
        setInstr(0, 4'd0, 2'd0, 32'd0, 32'd0);
        setBus(0, 0, 32'd0);
        applyInputs();
        modelReset();
        #2;
        doReset();

        // Word load, addr_ok then data_ok on consecutive cycles.
        clrCnt();
        setInstr(1, 4'b0000, SZ_WORD, 32'h0000_1000, 32'd0);
        cycle();
        setBus(1, 0, 32'd0); cycle();
        chk("t1_req_addr", data_addr, 32'h0000_1000);
        chk("t1_req_size", {30'd0, data_size}, 32'd2);
        setBus(0, 1, 32'hDEAD_BEEF); cycle();
        setBus(0, 0, 32'd0); cycle();
        chk("t1_rdata", mem_rdata, 32'hDEAD_BEEF);
        setInstr(0, 4'd0, 2'd0, 32'd0, 32'd0); cycle();
        chk("t1_stall_cycles", stallCycles, 3);
        chk("t1_req_cycles", reqCycles, 1);

        // Byte store with a slow address phase.
        clrCnt();
        setInstr(1, 4'b0100, SZ_BYTE, 32'h0000_2002, 32'h00AB_0000);
        cycle();
        repeat (3) cycle();
        chk("t2_wdata_stable", data_wdata, 32'h00AB_0000);
        setBus(1, 0, 32'd0); cycle();
        setBus(0, 1, 32'h5555_5555); cycle();
        setBus(0, 0, 32'd0); cycle();
        chk("t2_wr", {31'd0, data_wr}, 32'd1);
        setInstr(0, 4'd0, 2'd0, 32'd0, 32'd0); cycle();
        chk("t2_req_cycles", reqCycles, 4);
        chk("t2_stall_cycles", stallCycles, 6);
        chk("t2_rdata_kept", mem_rdata, 32'hDEAD_BEEF);

        // Load completing while another source keeps the pipeline held.
        clrCnt();
        vStall = 1;
        setInstr(1, 4'b0000, SZ_WORD, 32'h0000_3000, 32'd0);
        cycle();
        setBus(1, 0, 32'd0); cycle();
        setBus(0, 1, 32'h0BAD_F00D); cycle();
        setBus(0, 0, 32'd0);
        repeat (5) cycle();
        vStall = 0; cycle();
        setInstr(0, 4'd0, 2'd0, 32'd0, 32'd0); cycle();
        chk("t3_req_cycles", reqCycles, 1);
        chk("t3_free_cycles", freeCycles, 6);
        chk("t3_rdata", mem_rdata, 32'h0BAD_F00D);

        // Flush during the data phase: response drained and dropped.
        clrCnt();
        setInstr(1, 4'b0000, SZ_WORD, 32'h0000_4000, 32'd0);
        cycle();
        setBus(1, 0, 32'd0); cycle();
        setBus(0, 0, 32'd0); vFlush = 1; cycle();
        chk("t4_stall_on_flush", {31'd0, d_stall}, 32'd0);
        vFlush = 0;
        setInstr(0, 4'd0, 2'd0, 32'd0, 32'd0);
        setBus(0, 1, 32'h1234_5678); cycle();
        setBus(0, 0, 32'd0); cycle();
        chk("t4_rdata_kept", mem_rdata, 32'h0BAD_F00D);
        chk("t4_req_cycles", reqCycles, 1);

        // Back-to-back loads.
        clrCnt();
        setInstr(1, 4'b0000, SZ_WORD, 32'h0000_5000, 32'd0);
        cycle();
        setBus(1, 0, 32'd0); cycle();
        setBus(0, 1, 32'h1111_1111); cycle();
        setBus(0, 0, 32'd0); cycle();
        setInstr(1, 4'b0000, SZ_WORD, 32'h0000_5004, 32'd0);
        cycle();
        setBus(1, 0, 32'd0); cycle();
        chk("t5_second_addr", data_addr, 32'h0000_5004);
        chk("t5_second_req", {31'd0, data_req}, 32'd1);
        setBus(0, 1, 32'h2222_2222); cycle();
        setBus(0, 0, 32'd0); cycle();
        setInstr(0, 4'd0, 2'd0, 32'd0, 32'd0); cycle();
        chk("t5_req_cycles", reqCycles, 2);
        chk("t5_rdata", mem_rdata, 32'h2222_2222);

        // Reset while waiting for data; a late data_ok must be ignored.
        setInstr(1, 4'b0000, SZ_HALF, 32'h0000_6000, 32'd0);
        cycle();
        setBus(1, 0, 32'd0); cycle();
        setBus(0, 0, 32'd0); cycle();
        doReset();
        setBus(0, 1, 32'hFFFF_FFFF); cycle();
        setBus(0, 0, 32'd0); cycle();
        chk("t6_late_rdata", mem_rdata, 32'd0);

        // Randomized traffic.
        sBusy = 0; sCnt = 0; hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!hold) begin
                vEn   = ($urandom_range(0, 2) != 0);
                vSize = 2'($urandom_range(0, 2));
                vWen  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                vAddr = $urandom;
                vWdata = $urandom;
            end
            vFlush = ($urandom_range(0, 19) == 0);
            vStall = ($urandom_range(0, 3) == 0);
            vAddrOk = data_req && ($urandom_range(0, 1) != 0);
            vDataOk = sBusy && (sCnt == 0);
            vRdata  = $urandom;
            cycle();
            if (vDataOk) begin
                sBusy = 0;
            end else if (sBusy) begin
                sCnt--;
            end
            if (vAddrOk) begin
                sBusy = 1;
                sCnt = $urandom_range(0, 3);
            end
            hold = (lastExpStall | vStall) & ~vFlush;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
